// File: rtl/alu_pipe.sv
// Registered execute-stage ALU with MIPS R-type funct decode.
// ALU_MULDIV_EN adds the HI/LO multiply/divide sequencer.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [5:0]       func,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [SW-1:0]    sh;
  logic [WIDTH-1:0] add_r;
  logic [WIDTH-1:0] sub_r;
  logic             msb_a;
  logic             msb_b;
  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_ill;
  logic             seq_start;
  logic             seq_div;
  logic             fix_fire;
  logic [WIDTH-1:0] fix_lo;
  logic             fix_ovf;
  logic             fix_eq;
  logic             fire_d;
  logic [WIDTH-1:0] res_d;
  logic [3:0]       flags_d;
  logic             ill_d;

  assign sh     = operand_a[SW-1:0];
  assign add_r  = operand_a + operand_b;
  assign sub_r  = operand_a - operand_b;
  assign msb_a  = operand_a[WIDTH-1];
  assign msb_b  = operand_b[WIDTH-1];
  assign accept = in_valid && in_ready;

`ifdef ALU_MULDIV_EN
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] FIX  = 2'd3;

  logic [1:0]         state_q;
  logic [SW-1:0]      cnt_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   wlo_q;
  logic [WIDTH-1:0]   op_q;
  logic [WIDTH-1:0]   a_q;
  logic               eq_q;
  logic               negp_q;
  logic               nrem_q;
  logic               dz_q;
  logic               ov_q;
  logic               isdiv_q;

  logic               sgn;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   ma;
  logic [WIDTH-1:0]   mb;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic               last;

  assign in_ready = (state_q == IDLE) && rst_n;
  assign fix_fire = (state_q == FIX);
  assign fix_eq   = eq_q;
  assign last     = (cnt_q == SW'(WIDTH-1));

  // Operand magnitudes and one iteration step of each algorithm
  always_comb begin
    sgn = ~func[0];
    sa  = sgn & msb_a;
    sb  = sgn & msb_b;
    ma  = sa ? -operand_a : operand_a;
    mb  = sb ? -operand_b : operand_b;
    mul_sum = {1'b0, acc_q}
            + (wlo_q[0] ? {1'b0, op_q} : '0);
    div_sh   = {acc_q, wlo_q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, op_q});
    div_diff = div_sh[WIDTH-1:0] - op_q;
  end

  // Sign fix-up and special divide cases
  always_comb begin
    prod   = {acc_q, wlo_q};
    prod_s = negp_q ? -prod : prod;
    quo    = negp_q ? -wlo_q : wlo_q;
    rem    = nrem_q ? -acc_q : acc_q;
    fix_hi = prod_s[2*WIDTH-1:WIDTH];
    fix_lo = prod_s[WIDTH-1:0];
    if (isdiv_q) begin
      if (dz_q) begin
        fix_lo = '1;
        fix_hi = a_q;
      end else if (ov_q) begin
        fix_lo = MIN;
        fix_hi = '0;
      end else begin
        fix_lo = quo;
        fix_hi = rem;
      end
    end
    fix_ovf = isdiv_q && (dz_q || ov_q);
  end

  // Multiply/divide sequencer with HI/LO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      wlo_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      eq_q    <= 1'b0;
      negp_q  <= 1'b0;
      nrem_q  <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      isdiv_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && seq_start) begin
            state_q <= seq_div ? DIV : MUL;
            cnt_q   <= '0;
            acc_q   <= '0;
            wlo_q   <= seq_div ? ma : mb;
            op_q    <= seq_div ? mb : ma;
            a_q     <= operand_a;
            eq_q    <= (operand_a == operand_b);
            negp_q  <= sa ^ sb;
            nrem_q  <= sa;
            dz_q    <= seq_div && (operand_b == '0);
            ov_q    <= seq_div && sgn
                       && (operand_a == MIN)
                       && (operand_b == '1);
            isdiv_q <= seq_div;
          end
        end
        MUL: begin
          acc_q <= mul_sum[WIDTH:1];
          wlo_q <= {mul_sum[0], wlo_q[WIDTH-1:1]};
          cnt_q <= cnt_q + 1'b1;
          if (last) state_q <= FIX;
        end
        DIV: begin
          acc_q <= div_ge ? div_diff
                          : div_sh[WIDTH-1:0];
          wlo_q <= {wlo_q[WIDTH-2:0], div_ge};
          cnt_q <= cnt_q + 1'b1;
          if (last) state_q <= FIX;
        end
        default: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          state_q <= IDLE;
        end
      endcase
    end
  end
`else
  assign in_ready = rst_n;
  assign fix_fire = 1'b0;
  assign fix_lo   = '0;
  assign fix_ovf  = 1'b0;
  assign fix_eq   = 1'b0;
`endif

  // Single-cycle funct decode
  always_comb begin
    alu_res   = '0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    seq_start = 1'b0;
    seq_div   = 1'b0;
    case (func)
      6'd0, 6'd4: alu_res = operand_b << sh;
      6'd2, 6'd6: alu_res = operand_b >> sh;
      6'd3, 6'd7: alu_res = $signed(operand_b) >>> sh;
`ifdef ALU_MULDIV_EN
      6'd16: alu_res = hi_q;
      6'd18: alu_res = lo_q;
      6'd24, 6'd25: seq_start = 1'b1;
      6'd26, 6'd27: begin
        seq_start = 1'b1;
        seq_div   = 1'b1;
      end
`endif
      6'd32: begin
        alu_res = add_r;
        alu_ovf = (msb_a == msb_b)
               && (add_r[WIDTH-1] != msb_a);
      end
      6'd33: alu_res = add_r;
      6'd34: begin
        alu_res = sub_r;
        alu_ovf = (msb_a != msb_b)
               && (sub_r[WIDTH-1] != msb_a);
      end
      6'd35: alu_res = sub_r;
      6'd36: alu_res = operand_a & operand_b;
      6'd37: alu_res = operand_a | operand_b;
      6'd38: alu_res = operand_a ^ operand_b;
      6'd39: alu_res = ~(operand_a | operand_b);
      6'd42: alu_res = {{(WIDTH-1){1'b0}},
        ($signed(operand_a) < $signed(operand_b))};
      6'd43: alu_res = {{(WIDTH-1){1'b0}},
        (operand_a < operand_b)};
      default: alu_ill = 1'b1;
    endcase
  end

  // Select the value written back this cycle
  always_comb begin
    fire_d  = 1'b0;
    res_d   = '0;
    flags_d = '0;
    ill_d   = 1'b0;
    if (fix_fire) begin
      fire_d  = 1'b1;
      res_d   = fix_lo;
      flags_d = {fix_lo[WIDTH-1], fix_lo == '0,
                 fix_ovf, fix_eq};
    end else if (accept && !seq_start) begin
      fire_d = 1'b1;
      ill_d  = alu_ill;
      if (!alu_ill) begin
        res_d   = alu_res;
        flags_d = {alu_res[WIDTH-1], alu_res == '0,
                   alu_ovf, operand_a == operand_b};
      end
    end
  end

  // Registered writeback outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= fire_d;
      if (fire_d) begin
        result  <= res_d;
        flags   <= flags_d;
        illegal <= ill_d;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=32).
// Sequencer sequences run when ALU_MULDIV_EN is defined.
module tb_alu_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [5:0]  func;
  logic        out_valid;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        illegal;

  int checks;
  int failures;

  alu_pipe #(.WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .func(func),
    .out_valid(out_valid),
    .result(result),
    .flags(flags),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [3:0]  fl;
    logic [31:0] hi;
  } seq_t;

  vec_t tv[15];
  seq_t sv[5];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [5:0] f,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    func      = f;
    operand_a = a;
    operand_b = b;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string nm,
                         input logic [31:0] res,
                         input logic [3:0]  fl,
                         input logic        ill);
    chk({nm, ".valid"}, {31'b0, out_valid}, 32'd1);
    chk({nm, ".res"}, result, res);
    chk({nm, ".flags"}, {28'b0, flags}, {28'b0, fl});
    chk({nm, ".ill"}, {31'b0, illegal}, {31'b0, ill});
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    func      = '0;
    operand_a = '0;
    operand_b = '0;

    tv[0]  = '{6'd32, 32'h7FFFFFFF, 32'd1,
               32'h80000000, 4'b1010, 1'b0};
    tv[1]  = '{6'd33, 32'h7FFFFFFF, 32'd1,
               32'h80000000, 4'b1000, 1'b0};
    tv[2]  = '{6'd3, 32'd4, 32'hF0000000,
               32'hFF000000, 4'b1000, 1'b0};
    tv[3]  = '{6'd2, 32'd4, 32'hF0000000,
               32'h0F000000, 4'b0000, 1'b0};
    tv[4]  = '{6'd4, 32'd33, 32'd1,
               32'h00000002, 4'b0000, 1'b0};
    tv[5]  = '{6'd39, 32'd0, 32'd0,
               32'hFFFFFFFF, 4'b1001, 1'b0};
    tv[6]  = '{6'd34, 32'h80000000, 32'd1,
               32'h7FFFFFFF, 4'b0010, 1'b0};
    tv[7]  = '{6'd42, 32'hFFFFFFFF, 32'd1,
               32'h00000001, 4'b0000, 1'b0};
    tv[8]  = '{6'd43, 32'hFFFFFFFF, 32'd1,
               32'h00000000, 4'b0100, 1'b0};
    tv[9]  = '{6'd36, 32'h0000F0F0, 32'h00000FF0,
               32'h000000F0, 4'b0000, 1'b0};
    tv[10] = '{6'd38, 32'd5, 32'd5,
               32'h00000000, 4'b0101, 1'b0};
    tv[11] = '{6'd50, 32'd3, 32'd3,
               32'h00000000, 4'b0000, 1'b1};
    tv[12] = '{6'd35, 32'd0, 32'd1,
               32'hFFFFFFFF, 4'b1000, 1'b0};
    tv[13] = '{6'd0, 32'd31, 32'd3,
               32'h80000000, 4'b1000, 1'b0};
    tv[14] = '{6'd7, 32'd36, 32'h80000000,
               32'hF8000000, 4'b1000, 1'b0};

    sv[0] = '{6'd24, 32'hFFFFFFFD, 32'd7,
              32'hFFFFFFEB, 4'b1000, 32'hFFFFFFFF};
    sv[1] = '{6'd26, 32'hFFFFFFF9, 32'd2,
              32'hFFFFFFFD, 4'b1000, 32'hFFFFFFFF};
    sv[2] = '{6'd27, 32'd7, 32'd0,
              32'hFFFFFFFF, 4'b1010, 32'h00000007};
    sv[3] = '{6'd26, 32'h80000000, 32'hFFFFFFFF,
              32'h80000000, 4'b1010, 32'h00000000};
    sv[4] = '{6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'h00000001, 4'b0001, 32'hFFFFFFFE};

    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", {31'b0, out_valid}, 32'd0);
    chk("rst.res", result, 32'd0);
    chk("rst.flags", {28'b0, flags}, 32'd0);
    chk("rst.ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel.ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 15; i++) begin
      issue(tv[i].f, tv[i].a, tv[i].b);
      chk_out($sformatf("vec%0d", i),
              tv[i].res, tv[i].fl, tv[i].ill);
    end
    @(posedge clk);
    #1;
    chk("idle.valid", {31'b0, out_valid}, 32'd0);

`ifdef ALU_MULDIV_EN
    for (int i = 0; i < 5; i++) begin
      int n;
      int busy;
      logic [31:0] h;
      @(negedge clk);
      func      = sv[i].f;
      operand_a = sv[i].a;
      operand_b = sv[i].b;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      n    = 0;
      busy = 0;
      while (!out_valid && n < 100) begin
        if (!in_ready) busy++;
        @(posedge clk);
        #1;
        n++;
      end
      in_valid = 1'b0;
      chk($sformatf("seq%0d.edges", i), n, 33);
      chk($sformatf("seq%0d.busy", i), busy, 33);
      chk_out($sformatf("seq%0d", i),
              sv[i].lo, sv[i].fl, 1'b0);
      chk($sformatf("seq%0d.ready", i),
          {31'b0, in_ready}, 32'd1);
      issue(6'd16, 32'd0, 32'd0);
      h = sv[i].hi;
      chk_out($sformatf("seq%0d.mfhi", i), h,
              {h[31], h == 32'd0, 1'b0, 1'b1}, 1'b0);
    end

    begin
      int seen;
      seen = 0;
      issue(6'd24, 32'd5, 32'd5);
      repeat (9) begin
        if (out_valid) seen++;
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort.rstvalid", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("abort.ready", {31'b0, in_ready}, 32'd1);
      repeat (40) begin
        if (out_valid) seen++;
        @(posedge clk);
        #1;
      end
      chk("abort.pulses", seen, 0);
      issue(6'd18, 32'd0, 32'd0);
      chk_out("abort.mflo", 32'd0, 4'b0101, 1'b0);
      issue(6'd16, 32'd0, 32'd0);
      chk_out("abort.mfhi", 32'd0, 4'b0101, 1'b0);
    end
`else
    begin
      int low;
      low = 0;
      issue(6'd24, 32'hFFFFFFFD, 32'd7);
      chk_out("nomd.mult", 32'd0, 4'b0000, 1'b1);
      chk("nomd.ready", {31'b0, in_ready}, 32'd1);
      issue(6'd27, 32'd7, 32'd0);
      chk_out("nomd.divu", 32'd0, 4'b0000, 1'b1);
      issue(6'd16, 32'd0, 32'd0);
      chk_out("nomd.mfhi", 32'd0, 4'b0000, 1'b1);
      repeat (40) begin
        if (!in_ready) low++;
        @(posedge clk);
        #1;
      end
      chk("nomd.readylow", low, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
